alu_slice_seq: RTL and testbench
================================

Name: alu_slice_seq

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit 74181-style ALU.
- Keeps the full 16-function logic/arithmetic set selected by s[3:0] and m.
- Operand width is generalised; the datapath processes SLICE bits per clock, LSB slice first, with carry chained between slices in a register.
- Operands and results move over valid/ready handshakes. Sits between the operand sequencer and the result writeback stage.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per clock; 1 <= SLICE <= WIDTH. NSLICE = WIDTH/SLICE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand/command valid.
- in_ready  out  1  block can accept a command.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- s  in  4  function select.
- m  in  1  1 = logic mode, 0 = arithmetic mode.
- cin  in  1  carry in, active-high (1 adds +1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow.
- zero  out  1  f == 0.
- allones  out  1  f == all ones (comparator flag; A==B when s=0110, m=0, cin=0).

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE, in_ready=1, out_valid=0, f=0, cout=0, ovf=0, zero=0, allones=0, slice index=0, carry reg=0. Any in-flight command is discarded.
- FSM: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready at an edge: latch a, b, s, m, cin; carry reg <= cin; index <= 0; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each edge computes slice [index*SLICE +: SLICE] into the f register and updates the carry reg, then index++.
  - After the edge that computes slice NSLICE-1, go to DONE.
  - Latency: out_valid rises NSLICE edges after the accept edge. Example: WIDTH=16, SLICE=4 gives 4 edges.
- DONE:
  - out_valid=1; f and all flags are stable and held while out_ready=0.
  - in_ready=0, and in_valid is ignored.
  - Edge with out_ready=1: go to IDLE, out_valid=0. f and flags keep their value until the next command completes.
- No overlap: max throughput is one command per NSLICE+2 cycles.
- Logic mode (m=1), bitwise, cin ignored, cout=0, ovf=0:
  - 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 0.
  - 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B.
  - 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B.
  - 1100 all ones; 1101 A|~B; 1110 A|B; 1111 A.
- Arithmetic mode (m=0): result = X + Y + cin, modulo 2^WIDTH, where (X, Y) per s:
  - 0000 (A,0); 0001 (A|B,0); 0010 (A|~B,0); 0011 (ones,0).
  - 0100 (A,A&~B); 0101 (A|B,A&~B); 0110 (A,~B); 0111 (A&~B,ones).
  - 1000 (A,A&B); 1001 (A,B); 1010 (A|~B,A&B); 1011 (A&B,ones).
  - 1100 (A,A); 1101 (A|B,A); 1110 (A|~B,A); 1111 (A,ones).
- Arithmetic flags:
  - cout = carry out of bit WIDTH-1 of the full sum.
  - ovf = carry into bit WIDTH-1 XOR cout.
- zero and allones are evaluated on the final f and are valid only while out_valid=1.
- Result must be bit-identical to a single-cycle WIDTH-bit evaluation for every SLICE.

Optional Feature:
- Macro: ALU_SLICE_SEQ_ACC_EN.
- Defined:
  - Adds port use_acc (in, 1), sampled with the command.
  - When use_acc=1 at accept, operand A is replaced by the last completed f; after reset that value is 0.
  - The a input is ignored for that command.
- Undefined: port absent; A always comes from a.

Test Plan (WIDTH=16, SLICE=4):
- Add: s=1001, m=0, a=0x1234, b=0x0FCD, cin=0 -> f=0x2201, cout=0, ovf=0, zero=0; out_valid rises exactly 4 edges after accept.
- Subtract via cross-slice carry: s=0110, m=0, a=0x0005, b=0x0007, cin=1 -> f=0xFFFE, cout=0, ovf=0, allones=0.
- Wrap and overflow:
  - a=0xFFFF, b=0x0001, s=1001, m=0, cin=0 -> f=0x0000, cout=1, zero=1.
  - a=0x7FFF, b=0x0001 (same s, m, cin) -> f=0x8000, ovf=1, cout=0.
- Logic/comparator: s=1001, m=1, a=b=0xA5A5 -> f=0xFFFF, allones=1, cout=0.
  - Sweep all 16 s values with m=1 against the logic table.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> f and flags unchanged, in_ready=0, second command accepted only after the out_ready handshake.
- Reset after 2 BUSY cycles -> all outputs at reset values on the next sample, in_ready=1; the following command completes correctly.
- Repeat the add and subtract cases with SLICE=1 and SLICE=16: results identical, latency 16 and 1 edges.

Source files
------------

// File: rtl/alu_slice_seq.sv
// alu_slice_seq
// Multi-cycle 74181-style ALU. It supports the 16 logic and 16 arithmetic
// functions selected by s/m. It evaluates SLICE bits per clock, starting
// with the LSB slice, and keeps the inter-slice carry in a register.
//
// Parameters:
//   WIDTH - operand/result width; must be a multiple of SLICE
//   SLICE - bits evaluated per clock (1..WIDTH)
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid / in_ready  command handshake (a, b, s, m, cin)
//   use_acc              only with ALU_SLICE_SEQ_ACC_EN: take A from last f
//   out_valid/out_ready  result handshake (f, cout, ovf, zero, allones)
//
// Optional feature macro: ALU_SLICE_SEQ_ACC_EN (accumulator operand select).
module alu_slice_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef ALU_SLICE_SEQ_ACC_EN
  input  logic             use_acc,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             allones
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;

  // Operands shift right one slice per BUSY edge, so the active slice is
  // always at the bottom. Results shift in from the top of work.
  logic [WIDTH-1:0] opa, opb, work, work_next;
  logic [3:0]       fn_s;
  logic             fn_m;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic             last;

  logic [SLICE-1:0] sa, sb, x, y, lres, sum, res_slice;
  logic             c_slice, carry_next, msb_cin;

  assign sa   = opa[SLICE-1:0];
  assign sb   = opb[SLICE-1:0];
  assign last = (idx == IDXW'(NSLICE - 1));

  // All operand terms are bitwise, so one slice of X/Y/logic result only
  // depends on the matching slice of A and B.
  always_comb begin
    x    = '0;
    y    = '0;
    lres = '0;
    case (fn_s)
      4'b0000: begin lres = ~sa;          x = sa;        y = '0;       end
      4'b0001: begin lres = ~(sa | sb);   x = sa | sb;   y = '0;       end
      4'b0010: begin lres = ~sa & sb;     x = sa | ~sb;  y = '0;       end
      4'b0011: begin lres = '0;           x = '1;        y = '0;       end
      4'b0100: begin lres = ~(sa & sb);   x = sa;        y = sa & ~sb; end
      4'b0101: begin lres = ~sb;          x = sa | sb;   y = sa & ~sb; end
      4'b0110: begin lres = sa ^ sb;      x = sa;        y = ~sb;      end
      4'b0111: begin lres = sa & ~sb;     x = sa & ~sb;  y = '1;       end
      4'b1000: begin lres = ~sa | sb;     x = sa;        y = sa & sb;  end
      4'b1001: begin lres = ~(sa ^ sb);   x = sa;        y = sb;       end
      4'b1010: begin lres = sb;           x = sa | ~sb;  y = sa & sb;  end
      4'b1011: begin lres = sa & sb;      x = sa & sb;   y = '1;       end
      4'b1100: begin lres = '1;           x = sa;        y = sa;       end
      4'b1101: begin lres = sa | ~sb;     x = sa | sb;   y = sa;       end
      4'b1110: begin lres = sa | sb;      x = sa | ~sb;  y = sa;       end
      default: begin lres = sa;           x = sa;        y = '1;       end
    endcase
  end

  assign {c_slice, sum} = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, carry};
  assign res_slice  = fn_m ? lres : sum;
  assign carry_next = fn_m ? 1'b0 : c_slice;
  // Carry into the slice MSB recovered from its sum bit; on the last slice
  // this is the carry into bit WIDTH-1.
  assign msb_cin    = x[SLICE-1] ^ y[SLICE-1] ^ sum[SLICE-1];

  generate
    if (SLICE == WIDTH) begin : g_full
      assign work_next = res_slice;
    end else begin : g_part
      assign work_next = {res_slice, work[WIDTH-1:SLICE]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. f and flags are only written on the final slice, so they keep
  // the previous result until the next command completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      fn_s    <= '0;
      fn_m    <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      work    <= '0;
      f       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      allones <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_SLICE_SEQ_ACC_EN
            opa <= use_acc ? f : a;
`else
            opa <= a;
`endif
            opb   <= b;
            fn_s  <= s;
            fn_m  <= m;
            carry <= cin;
            idx   <= '0;
          end
        end
        BUSY: begin
          opa   <= opa >> SLICE;
          opb   <= opb >> SLICE;
          carry <= carry_next;
          idx   <= idx + IDXW'(1);
          work  <= work_next;
          if (last) begin
            f       <= work_next;
            cout    <= carry_next;
            ovf     <= fn_m ? 1'b0 : (msb_cin ^ c_slice);
            zero    <= (work_next == '0);
            allones <= &work_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Testbench for alu_slice_seq: three instances (SLICE = 4, 1, 16 at
// WIDTH = 16) share one command stream and are compared with a
// full-width behavioural model.
module tb_alu_slice_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [3:0]  s = '0;
  logic        m = 1'b0, cin = 1'b0;
`ifdef ALU_SLICE_SEQ_ACC_EN
  logic        use_acc = 1'b0;
`endif

  logic [2:0]  in_ready_o, out_valid_o, cout_o, ovf_o, zero_o, allones_o;
  logic [15:0] f_o [3];

  int checks = 0;
  int errors = 0;
  int lat [3];
  logic [15:0] last_f = '0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int SL = (gi == 0) ? 4 : (gi == 1) ? 1 : 16;
      alu_slice_seq #(.WIDTH(16), .SLICE(SL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[gi]),
`ifdef ALU_SLICE_SEQ_ACC_EN
        .use_acc(use_acc),
`endif
        .a(a), .b(b), .s(s), .m(m), .cin(cin),
        .out_valid(out_valid_o[gi]), .out_ready(out_ready),
        .f(f_o[gi]), .cout(cout_o[gi]), .ovf(ovf_o[gi]),
        .zero(zero_o[gi]), .allones(allones_o[gi])
      );
    end
  endgenerate

  function automatic int lat_exp(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  // Behavioural model: whole-word arithmetic. Returns {ovf, cout, f}.
  function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb,
                                        input logic [3:0] ts, input logic tm, input logic tc);
    logic [15:0] x, y, r;
    logic [16:0] sum;
    if (tm) begin
      case (ts)
        0: r = ~ta;          1: r = ~(ta | tb);   2: r = ~ta & tb;  3: r = 16'h0000;
        4: r = ~(ta & tb);   5: r = ~tb;          6: r = ta ^ tb;   7: r = ta & ~tb;
        8: r = ~ta | tb;     9: r = ~(ta ^ tb);   10: r = tb;       11: r = ta & tb;
        12: r = 16'hFFFF;    13: r = ta | ~tb;    14: r = ta | tb;  default: r = ta;
      endcase
      return {2'b00, r};
    end
    case (ts)
      0: begin x = ta; y = 0; end
      1: begin x = ta | tb; y = 0; end
      2: begin x = ta | ~tb; y = 0; end
      3: begin x = 16'hFFFF; y = 0; end
      4: begin x = ta; y = ta & ~tb; end
      5: begin x = ta | tb; y = ta & ~tb; end
      6: begin x = ta; y = ~tb; end
      7: begin x = ta & ~tb; y = 16'hFFFF; end
      8: begin x = ta; y = ta & tb; end
      9: begin x = ta; y = tb; end
      10: begin x = ta | ~tb; y = ta & tb; end
      11: begin x = ta & tb; y = 16'hFFFF; end
      12: begin x = ta; y = ta; end
      13: begin x = ta | tb; y = ta; end
      14: begin x = ta | ~tb; y = ta; end
      default: begin x = ta; y = 16'hFFFF; end
    endcase
    sum = 17'(x) + 17'(y) + 17'(tc);
    // signed overflow: operands of equal sign giving a result of the other sign
    return {(x[15] == y[15]) && (sum[15] != x[15]), sum[16], sum[15:0]};
  endfunction

  // Present a command, let the accept edge pass, then wait (bounded) for
  // every instance's out_valid, recording the edge count after accept.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb,
                       input logic [3:0] ts, input logic tm, input logic tc);
    a = ta; b = tb; s = ts; m = tm; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) lat[i] = -1;
    for (int k = 1; k <= 40 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (out_valid_o[i] && lat[i] < 0) lat[i] = k;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready_o[i], out_valid_o[i], f_o[i], cout_o[i], ovf_o[i], zero_o[i], allones_o[i]}
          !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
        errors++;
        $display("FAIL reset inst%0d: got rdy=%b vld=%b f=%h c=%b o=%b z=%b a1=%b, want rdy=1 vld=0 f=0000 flags=0",
                 i, in_ready_o[i], out_valid_o[i], f_o[i], cout_o[i], ovf_o[i], zero_o[i], allones_o[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] da [5] = '{16'h1234, 16'h0005, 16'hFFFF, 16'h7FFF, 16'hA5A5};
    logic [15:0] db [5] = '{16'h0FCD, 16'h0007, 16'h0001, 16'h0001, 16'hA5A5};
    logic        dm [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        dc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  ds [5] = '{4'b1001, 4'b0110, 4'b1001, 4'b1001, 4'b1001};
    // required {f, cout, ovf, zero, allones}
    logic [19:0] want [5] = '{{16'h2201, 4'b0000}, {16'hFFFE, 4'b0000}, {16'h0000, 4'b1010},
                              {16'h8000, 4'b0100}, {16'hFFFF, 4'b0001}};
    for (int t = 0; t < 5; t++) begin
      issue(da[t], db[t], ds[t], dm[t], dc[t]);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({f_o[i], cout_o[i], ovf_o[i], zero_o[i], allones_o[i]} !== want[t]) begin
          errors++;
          $display("FAIL directed%0d inst%0d: got f=%h c=%b o=%b z=%b a1=%b, want %h",
                   t, i, f_o[i], cout_o[i], ovf_o[i], zero_o[i], allones_o[i], want[t]);
        end
        checks++;
        if (lat[i] !== lat_exp(i)) begin
          errors++;
          $display("FAIL latency%0d inst%0d: got %0d edges, want %0d", t, i, lat[i], lat_exp(i));
        end
      end
      last_f = want[t][19:4];
      $display("directed %0d: a=%h b=%h s=%b m=%b cin=%b f=%h", t, da[t], db[t], ds[t], dm[t], dc[t], f_o[0]);
      release_result();
    end
  endtask

  // Shared by logic sweep and random: issue, compare all instances to model.
  task automatic run_model_cmd(input string name, input logic [15:0] ta, input logic [15:0] tb,
                               input logic [3:0] ts, input logic tm, input logic tc);
    logic [17:0] e;
    logic [19:0] ev;
    e  = model(ta, tb, ts, tm, tc);
    ev = {e[15:0], e[16], e[17], e[15:0] == 16'h0000, e[15:0] == 16'hFFFF};
    issue(ta, tb, ts, tm, tc);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid_o[i], f_o[i], cout_o[i], ovf_o[i], zero_o[i], allones_o[i]} !== {1'b1, ev}) begin
        errors++;
        $display("FAIL %s inst%0d a=%h b=%h s=%b m=%b cin=%b: got vld=%b f=%h c=%b o=%b z=%b a1=%b, want f=%h c=%b o=%b",
                 name, i, ta, tb, ts, tm, tc, out_valid_o[i], f_o[i], cout_o[i], ovf_o[i],
                 zero_o[i], allones_o[i], e[15:0], e[16], e[17]);
      end
    end
    last_f = e[15:0];
    $display("%s: a=%h b=%h s=%b m=%b cin=%b f=%h", name, ta, tb, ts, tm, tc, f_o[0]);
    release_result();
  endtask

  task automatic test_logic_sweep();
    for (int k = 0; k < 16; k++)
      run_model_cmd("logic", 16'($urandom), 16'($urandom), 4'(k), 1'b1, 1'($urandom));
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_model_cmd("random", 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom));
  endtask

  task automatic test_backpressure();
    logic [17:0] e;
    logic [15:0] na, nb;
    e = model(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b1);
    issue(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b1);
    na = 16'($urandom); nb = 16'($urandom);
    a = na; b = nb; s = 4'b0110; m = 1'b0; cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({in_ready_o[0], out_valid_o[0], f_o[0], cout_o[0], ovf_o[0]} !== {2'b01, e[15:0], e[16], e[17]}) begin
        errors++;
        $display("FAIL backpressure cycle%0d: got rdy=%b vld=%b f=%h c=%b o=%b, want rdy=0 vld=1 f=%h c=%b o=%b",
                 k, in_ready_o[0], out_valid_o[0], f_o[0], cout_o[0], ovf_o[0], e[15:0], e[16], e[17]);
      end
    end
    release_result();
    checks++;
    if ({in_ready_o[0], out_valid_o[0]} !== 2'b10) begin
      errors++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready_o[0], out_valid_o[0]);
    end
    $display("backpressure: held f=%h", f_o[0]);
    run_model_cmd("after_backpressure", na, nb, 4'b0110, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    a = 16'h0F0F; b = 16'h00FF; s = 4'b1001; m = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checks++;
    if ({in_ready_o[0], out_valid_o[0], f_o[0], cout_o[0], ovf_o[0], zero_o[0], allones_o[0]}
        !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b vld=%b f=%h c=%b o=%b z=%b a1=%b, want rdy=1 vld=0 f=0000 flags=0",
               in_ready_o[0], out_valid_o[0], f_o[0], cout_o[0], ovf_o[0], zero_o[0], allones_o[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_f = 16'h0000;
    $display("reset_mid: outputs cleared");
    run_model_cmd("after_reset", 16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b1);
  endtask

`ifdef ALU_SLICE_SEQ_ACC_EN
  task automatic test_acc();
    logic [17:0] e;
    for (int k = 0; k < 4; k++) begin
      e = model(last_f, 16'h0003, 4'b1001, 1'b0, 1'b0);
      use_acc = 1'b1;
      issue(16'($urandom), 16'h0003, 4'b1001, 1'b0, 1'b0);
      use_acc = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (f_o[i] !== e[15:0]) begin
          errors++;
          $display("FAIL acc%0d inst%0d: got f=%h, want %h", k, i, f_o[i], e[15:0]);
        end
      end
      last_f = e[15:0];
      $display("acc %0d: f=%h", k, f_o[0]);
      release_result();
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_directed();
    test_logic_sweep();
    test_random();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_SLICE_SEQ_ACC_EN
    test_acc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
